pipelined_alu: RTL and testbench
================================

PIPELINED_ALU -- requirements
Module: pipelined_alu

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width; SHALL be a multiple of 4 and at least 4.
REQ-002 Parameter: SAT_SUPPORT, default 1; when 0, the sat_en input SHALL be ignored.
REQ-003 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 enable  input  1  block enable; when 0, the pipeline freezes.
REQ-007 in_valid  input  1  operand set present.
REQ-008 in_ready  output  1  block can accept an operand set this cycle.
REQ-009 A, B  input  WIDTH  operands (two's complement for signed flags).
REQ-010 ALUOp  input  3  opcode: ADD=000, SUB=001, AND=010, OR=011, XOR=100, CMP=101, NAND=110, NOR=111.
REQ-011 sat_en  input  1  signed saturation for ADD/SUB, sampled with the operands.
REQ-012 out_valid  output  1  result and flags valid.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 result  output  WIDTH  operation result.
REQ-015 zero, negative, carry, overflow  output  1 each  result flags.

Function
REQ-016 Accept SHALL occur when in_valid & in_ready; stage 1 registers A, B, ALUOp and sat_en on accept.
REQ-017 Stage 2 SHALL compute from the stage-1 registers and register result, flags and out_valid; latency is exactly 2 cycles from accept to out_valid with no stall.
REQ-018 Stage 2 SHALL load when enable & (!out_valid | out_ready); stage 1 SHALL advance under the same condition.
REQ-019 in_ready SHALL be enable & (!s1_valid | stage-2-load); back-to-back accepts SHALL sustain 1 op/cycle.
REQ-020 result, the flags and out_valid SHALL hold while out_valid & !out_ready; no result is dropped or duplicated, and results emerge in order.
REQ-021 With enable=0: in_ready=0, all pipeline registers hold, and out_valid and result are unchanged (clock-gating point).
REQ-022 ADD: result = A+B via carry-lookahead; carry = carry-out of the MSB.
REQ-023 SUB: result = A+~B+1 on the same adder; carry = adder carry-out (1 = no borrow).
REQ-024 ADD/SUB overflow: for ADD, A and B have the same sign and the sum sign differs; for SUB, A and B differ in sign and the difference sign differs from A.
REQ-025 If sat_en and overflow: result SHALL be the signed max (0111...1) when A is positive, else the signed min (1000...0); overflow stays 1.
REQ-026 AND/OR/XOR/NAND/NOR: bitwise operation; carry=0, overflow=0.
REQ-027 CMP: result = 1 (zero-extended) if A==B, else 0; carry=0, overflow=0.
REQ-028 zero = (result==0); negative = result[WIDTH-1]; both derive from the final (possibly saturated) result.

Reset
REQ-029 While reset_n=0: s1_valid=0, out_valid=0, result=0, and all four flags=0; in_ready=0 asynchronously.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight operations; the first accept after release is on the first rising edge with reset_n=1.

Structure
REQ-031 Shared package alu_pkg SHALL hold the opcode constants and the flag-bundle typedef (zero, negative, carry, overflow).
REQ-032 One sub-module, cla_adder_n (parameter WIDTH), SHALL provide 4-bit lookahead groups with ripple between groups, with inputs A, B, Cin and outputs Sum, Cout.

Verification (WIDTH=8)
REQ-033 ADD 0x7F+0x01, sat_en=0 -> 2 cycles later: result=0x80, overflow=1, negative=1, carry=0, zero=0.
REQ-034 SUB 0x03-0x03 -> result=0x00, zero=1, carry=1, overflow=0; CMP 0x03,0x03 -> result=0x01, zero=0.
REQ-035 sat_en=1: ADD 0x7F+0x01 -> 0x7F, overflow=1; SUB 0x80-0x01 -> 0x80, overflow=1; ADD 0xFF+0x01 -> 0x00, carry=1, overflow=0.
REQ-036 Issue 3 back-to-back ops with out_ready=0 -> op1 held at the output, op2 in stage 1, in_ready=0, op3 not accepted; then out_ready=1 -> op1, op2, op3 emerge on consecutive cycles.
REQ-037 reset_n pulsed low with both stages valid -> out_valid=0 and result=0 immediately; no stale result after release.
REQ-038 enable=0 for 4 cycles with out_valid=1 -> in_ready=0 and result/flags/out_valid unchanged; enable=1 -> flow resumes.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and flag definitions for the pipelined ALU.
package alu_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_CMP  = 3'b101,
    OP_NAND = 3'b110,
    OP_NOR  = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/cla_adder_n.sv
// N-bit adder built from 4-bit carry-lookahead groups, carries rippling between groups.
module cla_adder_n #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int unsigned NGRP = WIDTH / 4;

  logic [NGRP:0] grp_c;

  assign grp_c[0] = Cin;

  for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g    = A[4*gi +: 4] & B[4*gi +: 4];
    assign p    = A[4*gi +: 4] ^ B[4*gi +: 4];
    assign c[0] = grp_c[gi];

    // Flat lookahead equations inside the group.
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign Sum[4*gi +: 4] = p ^ c[3:0];
    assign grp_c[gi+1]    = c[4];
  end

  assign Cout = grp_c[NGRP];

endmodule

// File: rtl/pipelined_alu.sv
// Two-stage valid/ready ALU: stage 1 captures operands, stage 2 computes and holds result + flags.
module pipelined_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter bit          SAT_SUPPORT = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OP_W-1:0]  ALUOp,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned      MSB  = WIDTH - 1;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  alu_op_e          s1_op_q, s1_op_d;
  logic             s1_sat_q, s1_sat_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  alu_flags_t       flags_q, flags_d;

  logic             s2_load_c;
  logic             accept_c;
  logic [WIDTH-1:0] add_b_c;
  logic             add_cin_c;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             add_ovf_c;
  logic [WIDTH-1:0] alu_res_c;
  alu_flags_t       alu_flags_c;

  // Handshake: stage 2 loads when the output slot is free or being drained.
  assign s2_load_c = enable & (~out_valid_q | out_ready);
  assign in_ready  = reset_n & enable & (~s1_valid_q | s2_load_c);
  assign accept_c  = in_valid & in_ready;

  // SUB reuses the adder as A + ~B + 1.
  assign add_b_c   = (s1_op_q == OP_SUB) ? ~s1_b_q : s1_b_q;
  assign add_cin_c = (s1_op_q == OP_SUB);

  cla_adder_n #(
    .WIDTH (WIDTH)
  ) u_adder (
    .A    (s1_a_q),
    .B    (add_b_c),
    .Cin  (add_cin_c),
    .Sum  (sum_c),
    .Cout (cout_c)
  );

  // Same-sign addends producing an opposite-sign sum; covers SUB through the inverted B.
  assign add_ovf_c = (s1_a_q[MSB] == add_b_c[MSB]) & (sum_c[MSB] != s1_a_q[MSB]);

  always_comb begin : alu_compute
    alu_res_c   = '0;
    alu_flags_c = '0;
    case (s1_op_q)
      OP_ADD, OP_SUB: begin
        alu_res_c            = sum_c;
        alu_flags_c.carry    = cout_c;
        alu_flags_c.overflow = add_ovf_c;
        if (SAT_SUPPORT && s1_sat_q && add_ovf_c) begin
          alu_res_c = s1_a_q[MSB] ? SMIN : SMAX;
        end
      end
      OP_AND:  alu_res_c = s1_a_q & s1_b_q;
      OP_OR:   alu_res_c = s1_a_q | s1_b_q;
      OP_XOR:  alu_res_c = s1_a_q ^ s1_b_q;
      OP_CMP:  alu_res_c = {{(WIDTH-1){1'b0}}, (s1_a_q == s1_b_q)};
      OP_NAND: alu_res_c = ~(s1_a_q & s1_b_q);
      OP_NOR:  alu_res_c = ~(s1_a_q | s1_b_q);
      default: alu_res_c = '0;
    endcase
    alu_flags_c.zero     = (alu_res_c == '0);
    alu_flags_c.negative = alu_res_c[MSB];
  end

  always_comb begin : next_state
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_op_d     = s1_op_q;
    s1_sat_d    = s1_sat_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;

    if (accept_c) begin
      s1_valid_d = 1'b1;
      s1_a_d     = A;
      s1_b_d     = B;
      s1_op_d    = alu_op_e'(ALUOp);
      s1_sat_d   = sat_en;
    end else if (s2_load_c) begin
      s1_valid_d = 1'b0;
    end

    // Result registers only change when a real operation moves in.
    if (s2_load_c) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = alu_res_c;
        flags_d  = alu_flags_c;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin : state_regs
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= OP_ADD;
      s1_sat_q    <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      s1_sat_q    <= s1_sat_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = flags_q.zero;
  assign negative  = flags_q.negative;
  assign carry     = flags_q.carry;
  assign overflow  = flags_q.overflow;

endmodule

// File: tb/tb_pipelined_alu.sv
// Directed plus randomized checks of pipelined_alu (WIDTH=8) against an arithmetic reference model.
module tb_pipelined_alu;
  import alu_pkg::*;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         enable;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   ALUOp;
  logic         sat_en;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero, negative, carry, overflow;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] res;
    logic       z;
    logic       n;
    logic       c;
    logic       v;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  pipelined_alu #(
    .WIDTH       (W),
    .SAT_SUPPORT (1'b1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ALUOp     (ALUOp),
    .sat_en    (sat_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .negative  (negative),
    .carry     (carry),
    .overflow  (overflow)
  );

  // Reference: signed/unsigned integer arithmetic straight from the opcode definitions.
  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic sat);
    exp_t        e;
    int          sa, sb, s;
    int unsigned u;
    e  = '0;
    sa = $signed(a);
    sb = $signed(b);
    case (alu_op_e'(op))
      OP_ADD: begin
        u     = 32'(a) + 32'(b);
        e.res = u[7:0];
        e.c   = u[8];
        s     = sa + sb;
        e.v   = (s > 127) || (s < -128);
      end
      OP_SUB: begin
        e.res = a - b;
        e.c   = (a >= b);
        s     = sa - sb;
        e.v   = (s > 127) || (s < -128);
      end
      OP_AND:  e.res = a & b;
      OP_OR:   e.res = a | b;
      OP_XOR:  e.res = a ^ b;
      OP_CMP:  e.res = (a == b) ? 8'd1 : 8'd0;
      OP_NAND: e.res = ~(a & b);
      default: e.res = ~(a | b);
    endcase
    if (sat && e.v) e.res = (sa >= 0) ? 8'h7F : 8'h80;
    e.z = (e.res == 8'd0);
    e.n = e.res[7];
    return e;
  endfunction

  function automatic exp_t mk(input logic [7:0] r, input logic z, input logic n, input logic c,
                              input logic v);
    exp_t e;
    e.res = r; e.z = z; e.n = n; e.c = c; e.v = v;
    return e;
  endfunction

  function automatic logic [7:0] pick();
    int unsigned k;
    k = $urandom_range(0, 5);
    if (k == 0) return 8'h00;
    if (k == 1) return 8'h7F;
    if (k == 2) return 8'h80;
    if (k == 3) return 8'hFF;
    return 8'($urandom);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_rf(input string tag, input exp_t e);
    chk({tag, ".result"}, 32'(result), 32'(e.res));
    chk({tag, ".flags"}, 32'({zero, negative, carry, overflow}), 32'({e.z, e.n, e.c, e.v}));
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk_rf(tag, e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic s);
    in_valid = v;
    ALUOp    = op;
    A        = a;
    B        = b;
    sat_en   = s;
    #1;
  endtask

  // One isolated operation: accept, confirm 2-cycle latency, check, drain.
  task automatic run_single(input string tag, input logic [2:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic s, input exp_t e);
    out_ready = 1'b1;
    drive(1'b1, op, a, b, s);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, op, a, b, s);
    chk({tag, ".lat1"}, 32'(out_valid), 32'd0);
    tick();
    chk_out(tag, e);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e1, e2, e3;
    logic [2:0] rop;
    logic [7:0] ra, rb;
    logic rs;

    reset_n   = 1'b0;
    enable    = 1'b1;
    out_ready = 1'b0;
    drive(1'b1, OP_ADD, 8'h01, 8'h02, 1'b0);
    tick();
    tick();
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.result", 32'(result), 32'd0);
    chk("rst.flags", 32'({zero, negative, carry, overflow}), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    drive(1'b0, OP_ADD, 8'h00, 8'h00, 1'b0);
    reset_n = 1'b1;
    tick();

    run_single("add_ovf", OP_ADD, 8'h7F, 8'h01, 1'b0, mk(8'h80, 1'b0, 1'b1, 1'b0, 1'b1));
    run_single("sub_zero", OP_SUB, 8'h03, 8'h03, 1'b0, mk(8'h00, 1'b1, 1'b0, 1'b1, 1'b0));
    run_single("cmp_eq", OP_CMP, 8'h03, 8'h03, 1'b0, mk(8'h01, 1'b0, 1'b0, 1'b0, 1'b0));
    run_single("sat_add", OP_ADD, 8'h7F, 8'h01, 1'b1, mk(8'h7F, 1'b0, 1'b0, 1'b0, 1'b1));
    run_single("sat_sub", OP_SUB, 8'h80, 8'h01, 1'b1, mk(8'h80, 1'b0, 1'b1, 1'b1, 1'b1));
    run_single("sat_wrap", OP_ADD, 8'hFF, 8'h01, 1'b1, mk(8'h00, 1'b1, 1'b0, 1'b1, 1'b0));
    run_single("sub_borrow", OP_SUB, 8'h01, 8'h02, 1'b0, mk(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0));
    run_single("and", OP_AND, 8'hF0, 8'h3C, 1'b1, mk(8'h30, 1'b0, 1'b0, 1'b0, 1'b0));
    run_single("nand", OP_NAND, 8'hF0, 8'h3C, 1'b0, mk(8'hCF, 1'b0, 1'b1, 1'b0, 1'b0));
    run_single("nor", OP_NOR, 8'h00, 8'h00, 1'b0, mk(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0));
    run_single("xor", OP_XOR, 8'hA5, 8'hA5, 1'b0, mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
    run_single("or", OP_OR, 8'h41, 8'h12, 1'b0, mk(8'h53, 1'b0, 1'b0, 1'b0, 1'b0));
    run_single("cmp_ne", OP_CMP, 8'h03, 8'h04, 1'b0, mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b0));

    // Backpressure: three back-to-back ops with downstream stalled.
    e1 = model(OP_ADD, 8'h10, 8'h20, 1'b0);
    e2 = model(OP_SUB, 8'h05, 8'h09, 1'b0);
    e3 = model(OP_XOR, 8'h5A, 8'h0F, 1'b0);
    out_ready = 1'b0;
    drive(1'b1, OP_ADD, 8'h10, 8'h20, 1'b0);
    chk("bp.rdy1", 32'(in_ready), 32'd1);
    tick();
    drive(1'b1, OP_SUB, 8'h05, 8'h09, 1'b0);
    chk("bp.rdy2", 32'(in_ready), 32'd1);
    tick();
    drive(1'b1, OP_XOR, 8'h5A, 8'h0F, 1'b0);
    chk("bp.rdy3", 32'(in_ready), 32'd0);
    chk_out("bp.hold1", e1);
    tick();
    chk("bp.rdy3b", 32'(in_ready), 32'd0);
    chk_out("bp.hold1b", e1);
    out_ready = 1'b1;
    #1;
    chk("bp.rdy_go", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, OP_ADD, 8'h00, 8'h00, 1'b0);
    chk_out("bp.op2", e2);
    tick();
    chk_out("bp.op3", e3);
    tick();
    chk("bp.empty", 32'(out_valid), 32'd0);

    // Reset with both stages occupied.
    out_ready = 1'b0;
    drive(1'b1, OP_ADD, 8'h11, 8'h22, 1'b0);
    tick();
    drive(1'b1, OP_OR, 8'h0F, 8'hF0, 1'b0);
    tick();
    drive(1'b0, OP_ADD, 8'h00, 8'h00, 1'b0);
    chk("mid.pre_valid", 32'(out_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid.out_valid", 32'(out_valid), 32'd0);
    chk("mid.result", 32'(result), 32'd0);
    chk("mid.flags", 32'({zero, negative, carry, overflow}), 32'd0);
    chk("mid.in_ready", 32'(in_ready), 32'd0);
    tick();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    e1 = model(OP_SUB, 8'h40, 8'h01, 1'b0);
    drive(1'b1, OP_SUB, 8'h40, 8'h01, 1'b0);
    chk("mid.first_rdy", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, OP_ADD, 8'h00, 8'h00, 1'b0);
    chk("mid.no_stale", 32'(out_valid), 32'd0);
    tick();
    chk_out("mid.first", e1);
    tick();

    // Enable low freezes everything even with downstream ready.
    e1 = model(OP_NAND, 8'h33, 8'h0F, 1'b0);
    e2 = model(OP_ADD, 8'h80, 8'h80, 1'b1);
    out_ready = 1'b0;
    drive(1'b1, OP_NAND, 8'h33, 8'h0F, 1'b0);
    tick();
    drive(1'b1, OP_ADD, 8'h80, 8'h80, 1'b1);
    tick();
    drive(1'b1, OP_AND, 8'hFF, 8'hFF, 1'b0);
    enable    = 1'b0;
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("en.in_ready", 32'(in_ready), 32'd0);
      chk_out("en.hold", e1);
      tick();
    end
    drive(1'b0, OP_ADD, 8'h00, 8'h00, 1'b0);
    enable = 1'b1;
    tick();
    chk_out("en.resume", e2);
    tick();
    chk("en.empty", 32'(out_valid), 32'd0);

    // Randomized traffic against a scoreboard.
    exp_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      enable    = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rop = 3'($urandom_range(0, 7));
      ra  = pick();
      rb  = pick();
      rs  = 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 1)), rop, ra, rb, rs);
      if (in_valid && in_ready) exp_q.push_back(model(rop, ra, rb, rs));
      if (enable && out_valid && out_ready) begin
        chk("rand.expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk_rf("rand", exp_q.pop_front());
      end
      tick();
    end

    enable    = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, OP_ADD, 8'h00, 8'h00, 1'b0);
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (out_valid) begin
        chk("drain.expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk_rf("drain", exp_q.pop_front());
      end
      tick();
    end
    chk("drain.left", 32'(exp_q.size()), 32'd0);
    chk("drain.valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
